sd_slot_arbiter: RTL and testbench

SD_SLOT_ARBITER -- requirements
Module: sd_slot_arbiter

---
 rtl/sd_arb_pkg.sv | 31 +++
 rtl/sd_arb_timeout.sv | 37 +++
 rtl/sd_slot_arbiter.sv | 173 +++++++++++++++++
 tb/tb_sd_slot_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_arb_pkg.sv
// Shared types and helpers for the two-slot SD block-request arbiter.
// Holds the controller state encoding, the operation encoding and the grant helpers.
package sd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    localparam int unsigned TMO_W = 24;

    // On a tie the slot that was not granted last wins.
    function automatic logic pick_slot(input logic [1:0] req, input logic last);
        if (req == 2'b11) begin
            return ~last;
        end
        return req[1];
    endfunction

    function automatic logic [1:0] slot_onehot(input logic slot);
        return slot ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sd_arb_timeout.sv
// Request-to-first-ack watchdog: counts while enabled, saturates at TIMEOUT_CYCLES-1.
// expired is decoded from the count register, so it never glitches.
module sd_arb_timeout
    import sd_arb_pkg::*;
#(
    parameter logic [TMO_W-1:0] TIMEOUT_CYCLES = 24'd8_400_000
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    assign expired = (cnt_q == (TIMEOUT_CYCLES - TMO_W'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sd_slot_arbiter.sv
// Shares one SD block-transfer host port between two image slots, round-robin.
// A grant latches slot, op and LBA; ack/strobe are routed back only to the granted slot.
module sd_slot_arbiter
    import sd_arb_pkg::*;
#(
    parameter logic [TMO_W-1:0] TIMEOUT_CYCLES = 24'd8_400_000,
    parameter int unsigned      SLOTS          = 2
) (
    input  logic        clk_sys,
    input  logic        reset_n,

    input  logic [31:0] slot0_lba,
    input  logic        slot0_rd,
    input  logic        slot0_wr,
    input  logic [7:0]  slot0_buff_din,
    output logic        slot0_ack,
    output logic        slot0_buff_wr,
    output logic        slot0_done,
    output logic        slot0_err,

    input  logic [31:0] slot1_lba,
    input  logic        slot1_rd,
    input  logic        slot1_wr,
    input  logic [7:0]  slot1_buff_din,
    output logic        slot1_ack,
    output logic        slot1_buff_wr,
    output logic        slot1_done,
    output logic        slot1_err,

    output logic [31:0] sd_lba,
    output logic [1:0]  sd_rd,
    output logic [1:0]  sd_wr,
    input  logic        sd_ack,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din,

    output logic        busy
);

    state_e           state_q, state_d;
    logic             grant_q, grant_d;
    op_e              op_q, op_d;
    logic [31:0]      lba_q, lba_d;
    logic             last_q, last_d;
    logic [1:0]       sd_rd_q, sd_rd_d;
    logic [1:0]       sd_wr_q, sd_wr_d;
    logic [1:0]       done_q, done_d;
    logic [1:0]       err_q, err_d;

    logic [SLOTS-1:0] req;
    logic [SLOTS-1:0] rd_bits;
    logic             win;
    logic             tmo_clear;
    logic             tmo_enable;
    logic             tmo_expired;

    assign req     = {slot1_rd | slot1_wr, slot0_rd | slot0_wr};
    assign rd_bits = {slot1_rd, slot0_rd};
    assign win     = pick_slot(req, last_q);

    assign tmo_enable = (state_q == ISSUE);

    sd_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .expired(tmo_expired)
    );

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        op_d      = op_q;
        lba_d     = lba_q;
        last_d    = last_q;
        done_d    = '0;
        err_d     = '0;
        tmo_clear = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d   = win;
                    lba_d     = win ? slot1_lba : slot0_lba;
                    // Read wins when both are raised; the write stays pending.
                    op_d      = rd_bits[win] ? OP_RD : OP_WR;
                    tmo_clear = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (sd_ack) begin
                    state_d = XFER;
                end else if (tmo_expired) begin
                    err_d   = slot_onehot(grant_q);
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            XFER: begin
                if (!sd_ack) begin
                    done_d  = slot_onehot(grant_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Host request lines are a registered decode of the next state.
        sd_rd_d = (state_d == ISSUE && op_d == OP_RD) ? slot_onehot(grant_d) : 2'b00;
        sd_wr_d = (state_d == ISSUE && op_d == OP_WR) ? slot_onehot(grant_d) : 2'b00;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            op_q    <= OP_RD;
            lba_q   <= '0;
            last_q  <= 1'b1;
            sd_rd_q <= '0;
            sd_wr_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            op_q    <= op_d;
            lba_q   <= lba_d;
            last_q  <= last_d;
            sd_rd_q <= sd_rd_d;
            sd_wr_q <= sd_wr_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    logic xfer0;
    logic xfer1;

    assign xfer0 = (state_q == XFER) && !grant_q;
    assign xfer1 = (state_q == XFER) &&  grant_q;

    assign slot0_ack     = xfer0 & sd_ack;
    assign slot0_buff_wr = xfer0 & sd_buff_wr;
    assign slot1_ack     = xfer1 & sd_ack;
    assign slot1_buff_wr = xfer1 & sd_buff_wr;

    assign slot0_done = done_q[0];
    assign slot1_done = done_q[1];
    assign slot0_err  = err_q[0];
    assign slot1_err  = err_q[1];

    assign sd_lba      = lba_q;
    assign sd_rd       = sd_rd_q;
    assign sd_wr       = sd_wr_q;
    assign sd_buff_din = grant_q ? slot1_buff_din : slot0_buff_din;
    assign busy        = (state_q != IDLE);

    // At most one host request bit may ever be high.
    a_req_onehot : assert property (@(posedge clk_sys) disable iff (!reset_n)
        $onehot0(sd_rd_q | sd_wr_q) && ((sd_rd_q & sd_wr_q) == 2'b00));

endmodule

// File: tb/tb_sd_slot_arbiter.sv
// Directed bench for sd_slot_arbiter: a simple host model answers requests,
// and each scenario task compares observed outputs against hand-derived values.
module tb_sd_slot_arbiter;

    logic        clk_sys;
    logic        reset_n;
    logic [31:0] slot0_lba, slot1_lba;
    logic        slot0_rd, slot0_wr, slot1_rd, slot1_wr;
    logic [7:0]  slot0_buff_din, slot1_buff_din;
    logic        slot0_ack, slot0_buff_wr, slot0_done, slot0_err;
    logic        slot1_ack, slot1_buff_wr, slot1_done, slot1_err;
    logic [31:0] sd_lba;
    logic [1:0]  sd_rd, sd_wr;
    logic        sd_ack, sd_buff_wr;
    logic [7:0]  sd_buff_din;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    int bw0_cnt = 0, bw1_cnt = 0, ack0_cnt = 0, ack1_cnt = 0;
    int done0_cnt = 0, done1_cnt = 0, err0_cnt = 0, err1_cnt = 0;
    int viol_cnt = 0;

    sd_slot_arbiter #(
        .TIMEOUT_CYCLES(24'd16),
        .SLOTS         (2)
    ) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .slot0_lba     (slot0_lba),
        .slot0_rd      (slot0_rd),
        .slot0_wr      (slot0_wr),
        .slot0_buff_din(slot0_buff_din),
        .slot0_ack     (slot0_ack),
        .slot0_buff_wr (slot0_buff_wr),
        .slot0_done    (slot0_done),
        .slot0_err     (slot0_err),
        .slot1_lba     (slot1_lba),
        .slot1_rd      (slot1_rd),
        .slot1_wr      (slot1_wr),
        .slot1_buff_din(slot1_buff_din),
        .slot1_ack     (slot1_ack),
        .slot1_buff_wr (slot1_buff_wr),
        .slot1_done    (slot1_done),
        .slot1_err     (slot1_err),
        .sd_lba        (sd_lba),
        .sd_rd         (sd_rd),
        .sd_wr         (sd_wr),
        .sd_ack        (sd_ack),
        .sd_buff_wr    (sd_buff_wr),
        .sd_buff_din   (sd_buff_din),
        .busy          (busy)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (slot0_buff_wr) bw0_cnt++;
        if (slot1_buff_wr) bw1_cnt++;
        if (slot0_ack)     ack0_cnt++;
        if (slot1_ack)     ack1_cnt++;
        if (slot0_done)    done0_cnt++;
        if (slot1_done)    done1_cnt++;
        if (slot0_err)     err0_cnt++;
        if (slot1_err)     err1_cnt++;
        if ($countones(sd_rd | sd_wr) > 1 || (sd_rd & sd_wr) != 2'b00) viol_cnt++;
    end

    initial begin
        #300_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        slot0_lba = '0; slot1_lba = '0;
        slot0_rd = 0; slot0_wr = 0; slot1_rd = 0; slot1_wr = 0;
        slot0_buff_din = 8'h5A; slot1_buff_din = 8'hA5;
        sd_ack = 0; sd_buff_wr = 0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
    endtask

    // Host model: waits for a request, drops the granted requester line, acks after
    // `delay` cycles, then strobes `nstrobe` bytes and drops ack.
    task automatic serve(input int delay, input int nstrobe,
                         output logic [1:0] rd_seen, output logic [1:0] wr_seen,
                         output logic [31:0] lba_seen, output logic [7:0] din_seen,
                         output bit ok);
        int waited;
        ok = 1'b1; rd_seen = '0; wr_seen = '0; lba_seen = '0; din_seen = '0;
        waited = 0;
        while ((sd_rd | sd_wr) == 2'b00 && waited < 50) begin
            @(negedge clk_sys);
            waited++;
        end
        if ((sd_rd | sd_wr) == 2'b00) begin
            ok = 1'b0;
            return;
        end
        rd_seen = sd_rd; wr_seen = sd_wr; lba_seen = sd_lba; din_seen = sd_buff_din;
        if (sd_rd[0]) slot0_rd = 1'b0;
        if (sd_wr[0]) slot0_wr = 1'b0;
        if (sd_rd[1]) slot1_rd = 1'b0;
        if (sd_wr[1]) slot1_wr = 1'b0;
        repeat (delay) begin
            @(negedge clk_sys);
            if (sd_rd !== rd_seen || sd_wr !== wr_seen) ok = 1'b0;
        end
        sd_ack = 1'b1;
        @(negedge clk_sys);
        if ((sd_rd | sd_wr) !== 2'b00) ok = 1'b0;
        repeat (nstrobe) begin
            sd_buff_wr = 1'b1;
            @(negedge clk_sys);
        end
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busy); end
        compared++; if ((sd_rd | sd_wr) !== 2'b00) begin mismatched++; $display("FAIL reset_req: got rd=%b wr=%b expected 00", sd_rd, sd_wr); end
        compared++; if (sd_lba !== 32'h0) begin mismatched++; $display("FAIL reset_lba: got %h expected 0", sd_lba); end
        compared++; if ({slot0_done, slot1_done, slot0_err, slot1_err} !== 4'b0) begin mismatched++; $display("FAIL reset_pulses: got %b expected 0000", {slot0_done, slot1_done, slot0_err, slot1_err}); end
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
    endtask

    task automatic test_idle_ignore();
        int a0, a1, b0, b1;
        a0 = ack0_cnt; a1 = ack1_cnt; b0 = bw0_cnt; b1 = bw1_cnt;
        sd_ack = 1'b1; sd_buff_wr = 1'b1;
        repeat (3) @(negedge clk_sys);
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL idle_ack_busy: got %b expected 0", busy); end
        sd_ack = 1'b0; sd_buff_wr = 1'b0;
        @(negedge clk_sys);
        compared++; if ((ack0_cnt - a0) + (ack1_cnt - a1) + (bw0_cnt - b0) + (bw1_cnt - b1) !== 0) begin
            mismatched++; $display("FAIL idle_ack_routed: got %0d routed cycles expected 0",
                (ack0_cnt - a0) + (ack1_cnt - a1) + (bw0_cnt - b0) + (bw1_cnt - b1));
        end
    endtask

    task automatic test_single_read();
        logic [1:0] rs, ws; logic [31:0] ls; logic [7:0] ds; bit ok;
        int b0, b1, a1, d0, d1, e0;
        b0 = bw0_cnt; b1 = bw1_cnt; a1 = ack1_cnt; d0 = done0_cnt; d1 = done1_cnt; e0 = err0_cnt;
        slot0_lba = 32'h100; slot0_rd = 1'b1;
        serve(3, 512, rs, ws, ls, ds, ok);
        repeat (3) @(negedge clk_sys);
        compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL rd_handshake: got ok=%b expected 1", ok); end
        compared++; if (rs !== 2'b01 || ws !== 2'b00) begin mismatched++; $display("FAIL rd_req: got rd=%b wr=%b expected rd=01 wr=00", rs, ws); end
        compared++; if (ls !== 32'h100) begin mismatched++; $display("FAIL rd_lba: got %h expected 00000100", ls); end
        compared++; if (bw0_cnt - b0 !== 512) begin mismatched++; $display("FAIL rd_strobes0: got %0d expected 512", bw0_cnt - b0); end
        compared++; if ((bw1_cnt - b1) + (ack1_cnt - a1) !== 0) begin mismatched++; $display("FAIL rd_slot1_quiet: got %0d expected 0", (bw1_cnt - b1) + (ack1_cnt - a1)); end
        compared++; if (done0_cnt - d0 !== 1 || done1_cnt - d1 !== 0) begin mismatched++; $display("FAIL rd_done: got %0d/%0d expected 1/0", done0_cnt - d0, done1_cnt - d1); end
        compared++; if (err0_cnt - e0 !== 0) begin mismatched++; $display("FAIL rd_err: got %0d expected 0", err0_cnt - e0); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rd_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] rs, ws; logic [31:0] ls; logic [7:0] ds; bit ok;
        int idle;
        apply_reset();
        for (int rep = 0; rep < 2; rep++) begin
            slot0_lba = 32'h200 + rep; slot1_lba = 32'h300 + rep;
            slot0_rd = 1'b1; slot1_rd = 1'b1;
            serve(1, 4, rs, ws, ls, ds, ok);
            compared++; if (ok !== 1'b1 || rs !== 2'b01 || ls !== 32'h200 + rep) begin
                mismatched++; $display("FAIL b2b_first_%0d: got ok=%b rd=%b lba=%h expected ok=1 rd=01 lba=%h", rep, ok, rs, ls, 32'h200 + rep);
            end
            idle = 0;
            for (int i = 0; i < 20 && (sd_rd | sd_wr) == 2'b00; i++) begin
                @(negedge clk_sys);
                if (!busy) idle++;
            end
            compared++; if (idle !== 1) begin mismatched++; $display("FAIL b2b_gap_%0d: got %0d idle cycles expected 1", rep, idle); end
            serve(1, 4, rs, ws, ls, ds, ok);
            compared++; if (ok !== 1'b1 || rs !== 2'b10 || ls !== 32'h300 + rep) begin
                mismatched++; $display("FAIL b2b_second_%0d: got ok=%b rd=%b lba=%h expected ok=1 rd=10 lba=%h", rep, ok, rs, ls, 32'h300 + rep);
            end
            repeat (3) @(negedge clk_sys);
        end
    endtask

    task automatic test_rd_wr_same_slot();
        logic [1:0] rs, ws; logic [31:0] ls; logic [7:0] ds; bit ok;
        int d1;
        d1 = done1_cnt;
        slot1_lba = 32'h400; slot1_rd = 1'b1; slot1_wr = 1'b1;
        serve(2, 3, rs, ws, ls, ds, ok);
        compared++; if (ok !== 1'b1 || rs !== 2'b10 || ws !== 2'b00) begin mismatched++; $display("FAIL rdwr_read: got ok=%b rd=%b wr=%b expected ok=1 rd=10 wr=00", ok, rs, ws); end
        serve(2, 3, rs, ws, ls, ds, ok);
        compared++; if (ok !== 1'b1 || ws !== 2'b10 || rs !== 2'b00) begin mismatched++; $display("FAIL rdwr_write: got ok=%b rd=%b wr=%b expected ok=1 rd=00 wr=10", ok, rs, ws); end
        compared++; if (ds !== 8'hA5) begin mismatched++; $display("FAIL rdwr_din_mux: got %h expected a5", ds); end
        repeat (3) @(negedge clk_sys);
        compared++; if (done1_cnt - d1 !== 2) begin mismatched++; $display("FAIL rdwr_done: got %0d expected 2", done1_cnt - d1); end
    endtask

    task automatic test_timeout();
        int hi, w, e0, d0, a0;
        e0 = err0_cnt; d0 = done0_cnt; a0 = ack0_cnt;
        slot0_lba = 32'h700; slot0_rd = 1'b1;
        w = 0;
        while (sd_rd == 2'b00 && w < 50) begin @(negedge clk_sys); w++; end
        slot0_rd = 1'b0;
        hi = 0;
        while (sd_rd != 2'b00 && hi < 40) begin hi++; @(negedge clk_sys); end
        compared++; if (hi !== 16) begin mismatched++; $display("FAIL tmo_req_cycles: got %0d expected 16", hi); end
        repeat (3) @(negedge clk_sys);
        compared++; if (err0_cnt - e0 !== 1) begin mismatched++; $display("FAIL tmo_err_pulse: got %0d expected 1", err0_cnt - e0); end
        compared++; if (busy !== 1'b0 || done0_cnt - d0 !== 0 || ack0_cnt - a0 !== 0) begin
            mismatched++; $display("FAIL tmo_idle: got busy=%b done=%0d ack=%0d expected 0/0/0", busy, done0_cnt - d0, ack0_cnt - a0);
        end
    endtask

    task automatic test_reset_mid_xfer();
        logic [1:0] rs, ws; logic [31:0] ls; logic [7:0] ds; bit ok;
        int w, d0, d1, b0;
        slot1_lba = 32'h500; slot1_rd = 1'b1;
        w = 0;
        while (sd_rd == 2'b00 && w < 50) begin @(negedge clk_sys); w++; end
        slot1_rd = 1'b0;
        sd_ack = 1'b1;
        @(negedge clk_sys);
        sd_buff_wr = 1'b1;
        @(negedge clk_sys);
        compared++; if (slot1_ack !== 1'b1 || slot1_buff_wr !== 1'b1 || slot0_ack !== 1'b0) begin
            mismatched++; $display("FAIL mid_route: got ack1=%b bw1=%b ack0=%b expected 1 1 0", slot1_ack, slot1_buff_wr, slot0_ack);
        end
        d1 = done1_cnt;
        #2 reset_n = 1'b0;
        #1;
        compared++; if ({slot1_ack, slot1_buff_wr, busy, slot1_done} !== 4'b0 || (sd_rd | sd_wr) !== 2'b00 || sd_lba !== 32'h0) begin
            mismatched++; $display("FAIL mid_reset_outputs: got ack1=%b bw1=%b busy=%b done1=%b req=%b lba=%h expected all 0",
                slot1_ack, slot1_buff_wr, busy, slot1_done, sd_rd | sd_wr, sd_lba);
        end
        @(negedge clk_sys);
        sd_ack = 1'b0; sd_buff_wr = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        compared++; if (done1_cnt - d1 !== 0 || busy !== 1'b0) begin mismatched++; $display("FAIL mid_no_done: got done1=%0d busy=%b expected 0/0", done1_cnt - d1, busy); end
        d0 = done0_cnt; b0 = bw0_cnt;
        slot0_lba = 32'h600; slot0_rd = 1'b1;
        serve(2, 8, rs, ws, ls, ds, ok);
        repeat (3) @(negedge clk_sys);
        compared++; if (ok !== 1'b1 || rs !== 2'b01 || ls !== 32'h600) begin mismatched++; $display("FAIL post_reset_req: got ok=%b rd=%b lba=%h expected 1 01 00000600", ok, rs, ls); end
        compared++; if (done0_cnt - d0 !== 1 || bw0_cnt - b0 !== 8) begin mismatched++; $display("FAIL post_reset_xfer: got done=%0d strobes=%0d expected 1/8", done0_cnt - d0, bw0_cnt - b0); end
    endtask

    task automatic test_onehot();
        compared++; if (viol_cnt !== 0) begin mismatched++; $display("FAIL onehot_req: got %0d violating cycles expected 0", viol_cnt); end
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_single_read();
        test_back_to_back();
        test_rd_wr_same_slot();
        test_timeout();
        test_reset_mid_xfer();
        test_onehot();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
